// File: rtl/dir_pkg.sv
// dir_pkg: directory state encodings, request priority and sharer-mask helper.
package dir_pkg;
  localparam logic [1:0] ST_UNCACHED  = 2'b00;
  localparam logic [1:0] ST_SHARED    = 2'b10;
  localparam logic [1:0] ST_EXCLUSIVE = 2'b11;
  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_RD,
    REQ_INV,
    REQ_WM,
    REQ_WB
  } req_e;
  function automatic req_e req_sel(input logic dwb, input logic wm, input logic inv, input logic rm);
    return dwb ? REQ_WB : wm ? REQ_WM : inv ? REQ_INV : rm ? REQ_RD : REQ_NONE;
  endfunction
  // Cache k owns bit w-1-k; w is at most 32.
  function automatic logic [31:0] sharer_bit(input logic id, input int unsigned w);
    return 32'd1 << (w - 32'd1 - {31'd0, id});
  endfunction
endpackage

// File: rtl/dir_next_state.sv
// dir_next_state: combinational next directory state, sharer vector and command pulses.
// Inputs: request (requester_id, read_miss, invalidate_req, write_miss, data_write_back),
//   line state (cur_state, cur_sharers). Outputs: new_state, new_sharers, write_back,
//   fetch, invalidate, data_reply, and proto_err when DIR_PROTO_CHECK_EN is defined.
module dir_next_state
  import dir_pkg::*;
#(
  parameter int SHARER_W = 4
) (
  input  logic                requester_id,
  input  logic                read_miss,
  input  logic                invalidate_req,
  input  logic                write_miss,
  input  logic                data_write_back,
  input  logic [1:0]          cur_state,
  input  logic [SHARER_W-1:0] cur_sharers,
  output logic [1:0]          new_state,
  output logic [SHARER_W-1:0] new_sharers,
  output logic                write_back,
  output logic                fetch,
  output logic                invalidate,
  output logic                data_reply
`ifdef DIR_PROTO_CHECK_EN
  ,
  output logic                proto_err
`endif
);
  logic [31:0] r_w, o_w;
  logic [SHARER_W-1:0] r, o, cur_m;
  logic shrd, excl, unc, own_r, own_o, has_o;
  req_e req;
  assign r_w   = sharer_bit(requester_id, SHARER_W);
  assign o_w   = sharer_bit(~requester_id, SHARER_W);
  assign r     = r_w[SHARER_W-1:0];
  assign o     = o_w[SHARER_W-1:0];
  // Reserved low bits are cleared on every write-back to the directory.
  assign cur_m = cur_sharers & (r | o);
  assign req   = req_sel(data_write_back, write_miss, invalidate_req, read_miss);
  assign unc   = !cur_state[1];
  assign shrd  = cur_state == ST_SHARED;
  assign excl  = cur_state == ST_EXCLUSIVE;
  assign has_o = |(cur_sharers & o);
  // An EXCLUSIVE line only has a usable owner when its vector is exactly that one bit.
  assign own_r = excl && cur_sharers == r;
  assign own_o = excl && cur_sharers == o;
  always_comb begin
    new_state   = cur_state;
    new_sharers = cur_m;
    write_back  = 1'b0;
    fetch       = 1'b0;
    invalidate  = 1'b0;
    data_reply  = 1'b0;
    if (unc) begin
      if (req == REQ_RD || req == REQ_WM) begin
        new_state   = req == REQ_WM ? ST_EXCLUSIVE : ST_SHARED;
        new_sharers = r;
        data_reply  = 1'b1;
      end
    end else if (shrd) begin
      if (req == REQ_RD) begin
        new_sharers = cur_m | r;
        data_reply  = 1'b1;
      end else if (req == REQ_WM || req == REQ_INV) begin
        new_state   = ST_EXCLUSIVE;
        new_sharers = r;
        invalidate  = has_o;
        data_reply  = req == REQ_WM;
      end
    end else if (own_o) begin
      if (req == REQ_RD || req == REQ_WM) begin
        new_state   = req == REQ_WM ? ST_EXCLUSIVE : ST_SHARED;
        new_sharers = req == REQ_WM ? r : (o | r);
        fetch       = 1'b1;
        write_back  = 1'b1;
        invalidate  = req == REQ_WM;
        data_reply  = 1'b1;
      end
    end else if (own_r) begin
      if (req == REQ_RD || req == REQ_WM) begin
        data_reply = 1'b1;
      end else if (req == REQ_WB) begin
        new_state   = ST_UNCACHED;
        new_sharers = '0;
        write_back  = 1'b1;
      end
    end
  end
`ifdef DIR_PROTO_CHECK_EN
  assign proto_err = (req == REQ_WB && !own_r) || (req == REQ_INV && !shrd) ||
                     (req != REQ_NONE && (cur_state == 2'b01 || (excl && !$onehot(cur_sharers))));
`endif
endmodule

// File: rtl/directory_fsm.sv
// directory_fsm: per-line two-core directory controller with registered outputs.
// Inputs: clk, rst_n (async active-low), requester_id, read_miss, invalidate_req,
//   write_miss, data_write_back, cur_state, cur_sharers.
// Outputs (one cycle after sampling): new_state, new_sharers, write_back, fetch,
//   invalidate, data_reply; proto_err is added when DIR_PROTO_CHECK_EN is defined.
module directory_fsm
  import dir_pkg::*;
#(
  parameter int SHARER_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                requester_id,
  input  logic                read_miss,
  input  logic                invalidate_req,
  input  logic                write_miss,
  input  logic                data_write_back,
  input  logic [1:0]          cur_state,
  input  logic [SHARER_W-1:0] cur_sharers,
  output logic [1:0]          new_state,
  output logic                write_back,
  output logic                fetch,
  output logic                invalidate,
  output logic                data_reply,
  output logic [SHARER_W-1:0] new_sharers
`ifdef DIR_PROTO_CHECK_EN
  ,
  output logic                proto_err
`endif
);
  logic [1:0] state_d, state_q;
  logic [SHARER_W-1:0] sharers_d, sharers_q;
  logic [3:0] pulse_d, pulse_q;
`ifdef DIR_PROTO_CHECK_EN
  logic perr_d, perr_q;
`endif
  dir_next_state #(.SHARER_W(SHARER_W)) u_next (
    .requester_id    (requester_id),
    .read_miss       (read_miss),
    .invalidate_req  (invalidate_req),
    .write_miss      (write_miss),
    .data_write_back (data_write_back),
    .cur_state       (cur_state),
    .cur_sharers     (cur_sharers),
    .new_state       (state_d),
    .new_sharers     (sharers_d),
    .write_back      (pulse_d[3]),
    .fetch           (pulse_d[2]),
    .invalidate      (pulse_d[1]),
    .data_reply      (pulse_d[0])
`ifdef DIR_PROTO_CHECK_EN
    ,
    .proto_err       (perr_d)
`endif
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_UNCACHED;
      sharers_q <= '0;
      pulse_q   <= '0;
`ifdef DIR_PROTO_CHECK_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sharers_q <= sharers_d;
      pulse_q   <= pulse_d;
`ifdef DIR_PROTO_CHECK_EN
      perr_q    <= perr_d;
`endif
    end
  end
  always_comb begin
    new_state   = state_q;
    new_sharers = sharers_q;
    write_back  = pulse_q[3];
    fetch       = pulse_q[2];
    invalidate  = pulse_q[1];
    data_reply  = pulse_q[0];
`ifdef DIR_PROTO_CHECK_EN
    proto_err   = perr_q;
`endif
  end
endmodule

// File: tb/tb_directory_fsm.sv
// tb_directory_fsm: directed-vector self-checking bench for directory_fsm.
module tb_directory_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic requester_id = 1'b0, read_miss = 1'b0, invalidate_req = 1'b0, write_miss = 1'b0, data_write_back = 1'b0;
  logic [1:0] cur_state = 2'b00;
  logic [3:0] cur_sharers = 4'b0000;
  logic [1:0] new_state;
  logic [3:0] new_sharers;
  logic write_back, fetch, invalidate, data_reply;
`ifdef DIR_PROTO_CHECK_EN
  logic proto_err;
`endif
  int n_chk = 0;
  int n_fail = 0;
  directory_fsm #(.SHARER_W(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .requester_id    (requester_id),
    .read_miss       (read_miss),
    .invalidate_req  (invalidate_req),
    .write_miss      (write_miss),
    .data_write_back (data_write_back),
    .cur_state       (cur_state),
    .cur_sharers     (cur_sharers),
    .new_state       (new_state),
    .write_back      (write_back),
    .fetch           (fetch),
    .invalidate      (invalidate),
    .data_reply      (data_reply),
    .new_sharers     (new_sharers)
`ifdef DIR_PROTO_CHECK_EN
    ,
    .proto_err       (proto_err)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Observed word: {state, sharers, write_back, fetch, invalidate, data_reply}
  function automatic logic [31:0] obs();
    return {22'd0, new_state, new_sharers, write_back, fetch, invalidate, data_reply};
  endfunction
  task automatic drive(input logic rid, input logic [3:0] req, input logic [1:0] cs, input logic [3:0] csh);
    requester_id = rid;
    {data_write_back, write_miss, invalidate_req, read_miss} = req;
    cur_state = cs;
    cur_sharers = csh;
  endtask
  // req = {dwb, wm, inv, rm}; ep = {wb, fetch, inv, dr}
  task automatic vec(input string tag, input logic rid, input logic [3:0] req, input logic [1:0] cs,
                     input logic [3:0] csh, input logic [1:0] es, input logic [3:0] esh,
                     input logic [3:0] ep, input logic eperr);
    @(negedge clk);
    drive(rid, req, cs, csh);
    @(posedge clk);
    #1;
    check(tag, obs(), {22'd0, es, esh, ep});
`ifdef DIR_PROTO_CHECK_EN
    check({tag, "_perr"}, {31'd0, proto_err}, {31'd0, eperr});
`else
    if (eperr === 1'bx) check({tag, "_perr"}, 32'd0, 32'd1);
`endif
  endtask
  initial begin
    drive(1'b1, 4'b1111, 2'b11, 4'b0100);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", obs(), 32'd0);
`ifdef DIR_PROTO_CHECK_EN
    check("reset_perr", {31'd0, proto_err}, 32'd0);
`endif
    @(negedge clk);
    drive(1'b1, 4'b0001, 2'b00, 4'b0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", obs(), {22'd0, 2'b10, 4'b0100, 4'b0001});
    vec("unc_rm",        1'b1, 4'b0001, 2'b00, 4'b0000, 2'b10, 4'b0100, 4'b0001, 1'b0);
    vec("unc_wm",        1'b1, 4'b0100, 2'b00, 4'b0000, 2'b11, 4'b0100, 4'b0001, 1'b0);
    vec("sh_upgrade",    1'b0, 4'b0010, 2'b10, 4'b1100, 2'b11, 4'b1000, 4'b0010, 1'b0);
    vec("sh_wm",         1'b0, 4'b0100, 2'b10, 4'b1100, 2'b11, 4'b1000, 4'b0011, 1'b0);
    vec("ex_remote_rm",  1'b1, 4'b0001, 2'b11, 4'b1000, 2'b10, 4'b1100, 4'b1101, 1'b0);
    vec("ex_owner_wb",   1'b0, 4'b1000, 2'b11, 4'b1000, 2'b00, 4'b0000, 4'b1000, 1'b0);
    vec("ex_illegal_wb", 1'b1, 4'b1000, 2'b11, 4'b1000, 2'b11, 4'b1000, 4'b0000, 1'b1);
    vec("prio_wb_rm",    1'b0, 4'b1001, 2'b11, 4'b1000, 2'b00, 4'b0000, 4'b1000, 1'b0);
    vec("sh_add_rm",     1'b0, 4'b0001, 2'b10, 4'b0100, 2'b10, 4'b1100, 4'b0001, 1'b0);
    vec("sh_upg_remote", 1'b1, 4'b0010, 2'b10, 4'b1000, 2'b11, 4'b0100, 4'b0010, 1'b0);
    vec("sh_upg_alone",  1'b1, 4'b0010, 2'b10, 4'b0100, 2'b11, 4'b0100, 4'b0000, 1'b0);
    vec("ex_remote_wm",  1'b0, 4'b0100, 2'b11, 4'b0100, 2'b11, 4'b1000, 4'b1111, 1'b0);
    vec("ex_own_wm",     1'b0, 4'b0100, 2'b11, 4'b1000, 2'b11, 4'b1000, 4'b0001, 1'b0);
    vec("unc_inv",       1'b0, 4'b0010, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000, 1'b1);
    vec("idle_resv",     1'b0, 4'b0000, 2'b10, 4'b1111, 2'b10, 4'b1100, 4'b0000, 1'b0);
    vec("st01_rm",       1'b0, 4'b0001, 2'b01, 4'b0000, 2'b10, 4'b1000, 4'b0001, 1'b1);
    vec("ex_bad_vec",    1'b1, 4'b0001, 2'b11, 4'b1100, 2'b11, 4'b1100, 4'b0000, 1'b1);
    vec("prio_wm_inv",   1'b0, 4'b0111, 2'b00, 4'b0000, 2'b11, 4'b1000, 4'b0001, 1'b0);
    vec("prio_wm_rm",    1'b1, 4'b0101, 2'b10, 4'b1000, 2'b11, 4'b0100, 4'b0011, 1'b0);
    vec("pulse_drop",    1'b0, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000, 1'b0);
    vec("ex_remote_rm2", 1'b0, 4'b0001, 2'b11, 4'b0100, 2'b10, 4'b1100, 4'b1101, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_reset", obs(), 32'd0);
    @(negedge clk);
    drive(1'b0, 4'b0100, 2'b00, 4'b0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_wm", obs(), {22'd0, 2'b11, 4'b1000, 4'b0001});
    @(negedge clk);
    drive(1'b0, 4'b0000, 2'b00, 4'b0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
